// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - control inputs and note/status outputs of note_sequencer
//
// Ports carried by the interface:
//   mode         (3)  game mode code from the mode FSM
//   lane_btn     (4)  lane button levels
//   pushed_store (1)  store/select button level
//   note_count   (6)  notes played so far
//   note_out     (4)  lane pattern of the most recent step
//   note_valid   (1)  one-cycle pulse when note_out updates
//   difficulty   (2)  playback speed select
//   edit_ptr     (6)  next pattern entry to be written
// master: drives the controls and observes the outputs; slave: the sequencer.
interface note_sequencer_if;
  logic [2:0] mode;
  logic [3:0] lane_btn;
  logic       pushed_store;
  logic [5:0] note_count;
  logic [3:0] note_out;
  logic       note_valid;
  logic [1:0] difficulty;
  logic [5:0] edit_ptr;

  modport master (
    output mode, lane_btn, pushed_store,
    input  note_count, note_out, note_valid, difficulty, edit_ptr
  );

  modport slave (
    input  mode, lane_btn, pushed_store,
    output note_count, note_out, note_valid, difficulty, edit_ptr
  );
endinterface

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - per-song note pattern storage and timed playback
//
// Records a SONG_LEN-step lane pattern in EDIT, selects the playback speed in
// DIFF and steps through the pattern in RUN, one note every
// STEP_DIV >> difficulty cycles.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  note_sequencer_if.slave (mode, lane_btn, pushed_store in;
//        note_count, note_out, note_valid, difficulty, edit_ptr out)
//
// Build option: NOTE_SEQ_DEFAULT_SONG_EN preloads a lane 0,1,2,3 repeating
// pattern at reset; otherwise the pattern resets to all zeros.
module note_sequencer #(
  parameter int SONG_LEN = 41,
  parameter int STEP_DIV = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  note_sequencer_if.slave bus
);

  localparam int CW = $clog2(STEP_DIV);
  localparam logic [5:0] LEN      = 6'(SONG_LEN);
  localparam logic [5:0] PTR_LAST = 6'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    M_IDLE0  = 3'd0,
    M_IDLE   = 3'd1,
    M_EDIT   = 3'd2,
    M_DIFF   = 3'd3,
    M_RUN    = 3'd4,
    M_PAUSE  = 3'd5,
    M_FINISH = 3'd6,
    M_IDLE7  = 3'd7
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(bus.mode);

  logic          s1_q, s1_d, s2_q, s2_d;
  logic [CW-1:0] step_q, step_d;
  logic [5:0]    count_q, count_d;
  logic [3:0]    out_q, out_d;
  logic          valid_q, valid_d;
  logic [1:0]    diff_q, diff_d;
  logic [5:0]    ptr_q, ptr_d;
  logic [3:0]    mem_q [SONG_LEN];
  logic [3:0]    mem_d [SONG_LEN];

  logic          evt;
  logic [CW-1:0] period_m1;

  // Rising edge of the store button, one cycle wide.
  assign evt = s1_q & ~s2_q;

  // P-1 always fits in CW bits even when P itself is a power of two.
  assign period_m1 = CW'((STEP_DIV >> diff_q) - 1);

  always_comb begin
    s1_d    = bus.pushed_store;
    s2_d    = s1_q;
    step_d  = step_q;
    count_d = count_q;
    out_d   = out_q;
    valid_d = 1'b0;
    diff_d  = diff_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;

    case (mode)
      M_EDIT: begin
        if (evt) begin
          mem_d[ptr_q] = bus.lane_btn;
          ptr_d        = (ptr_q == PTR_LAST) ? 6'd0 : ptr_q + 6'd1;
        end
      end
      M_DIFF: begin
        if (evt) begin
          diff_d = (diff_q == 2'd2) ? 2'd0 : diff_q + 2'd1;
        end
      end
      M_RUN: begin
        // Once the song is complete the counter and count freeze.
        if (count_q < LEN) begin
          // >= keeps the counter bounded if the speed changed mid-song.
          if (step_q >= period_m1) begin
            step_d  = '0;
            out_d   = mem_q[count_q];
            valid_d = 1'b1;
            count_d = count_q + 6'd1;
          end else begin
            step_d = step_q + CW'(1);
          end
        end
      end
      M_PAUSE: begin
      end
      M_FINISH: begin
        out_d = '0;
      end
      default: begin
        // IDLE and the unused codes 0 and 7; pattern and speed are kept.
        count_d = '0;
        step_d  = '0;
        out_d   = '0;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      step_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      diff_q  <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < SONG_LEN; i++) begin
`ifdef NOTE_SEQ_DEFAULT_SONG_EN
        mem_q[i] <= 4'b0001 << (i % 4);
`else
        mem_q[i] <= 4'b0000;
`endif
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      step_q  <= step_d;
      count_q <= count_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      diff_q  <= diff_d;
      ptr_q   <= ptr_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.note_count = count_q;
  assign bus.note_out   = out_q;
  assign bus.note_valid = valid_q;
  assign bus.difficulty = diff_q;
  assign bus.edit_ptr   = ptr_q;

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Per-song note storage and playback stage that sits directly downstream of the game mode FSM and feeds its `note_count` input. In EDIT it records a 41-step lane pattern from the lane buttons. In DIFF it selects the playback speed. In RUN it steps through the pattern at the selected rate, emitting one note per step and counting notes played; the FSM moves to FINISH when the count reaches the song length.

## Interface
- `SONG_LEN`, 41: number of pattern entries; also the terminal `note_count` value.
- `STEP_DIV`, 1_000_000: clock cycles per step at difficulty 0; must be ≥ 4.
- `clk`  in  1  system clock; every flop is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `mode`  in  3  FSM mode: IDLE=1, EDIT=2, DIFF=3, RUN=4, PAUSE=5, FINISH=6; any other code is treated as IDLE.
- `lane_btn`  in  4  lane button levels, one bit per lane.
- `pushed_store`  in  1  store/select button level.
- `note_count`  out  6  notes played, 0..SONG_LEN.
- `note_out`  out  4  lane pattern of the most recent step.
- `note_valid`  out  1  one-cycle pulse when `note_out` is updated.
- `difficulty`  out  2  0=easy, 1=medium, 2=hard.
- `edit_ptr`  out  6  next pattern entry to be written, 0..SONG_LEN-1.

## Operation
- Reset values: `note_count`=0, `note_out`=0, `note_valid`=0, `difficulty`=0, `edit_ptr`=0, step counter=0, edge flops=0, pattern memory per Configuration.
- Store event: two-flop edge detector, `s1<=pushed_store`, `s2<=s1`, `evt = s1 & ~s2`. The edge flops run in every mode.
- Step period `P = STEP_DIV >> difficulty`.
- IDLE: clear `note_count`, step counter, `note_out`, `edit_ptr`. Pattern memory and `difficulty` are retained.
- EDIT: on `evt`, `mem[edit_ptr] <= lane_btn`. `edit_ptr` increments and wraps from SONG_LEN-1 to 0.
- DIFF: on `evt`, `difficulty` steps 0→1→2→0.
- RUN: step counter counts 0..P-1. At the edge where it equals P-1 and `note_count < SONG_LEN`:
  - step counter ← 0
  - `note_out` ← `mem[note_count]`
  - `note_valid` ← 1
  - `note_count` ← +1
- RUN once `note_count == SONG_LEN`: the step counter and `note_count` freeze and no further `note_valid` pulses occur.
- PAUSE: step counter, `note_count` and `note_out` hold. On return to RUN, counting resumes from the held value.
- FINISH: `note_count` holds, `note_out` is forced to 0, and no pulses occur.
- `evt` in RUN, PAUSE, FINISH or IDLE has no effect.
- `lane_btn` is sampled only when a write occurs.
- Mode codes 0 and 7 behave exactly as IDLE.

## Timing
- `pushed_store` first sampled high at edge N → `s1` high after N → `evt` high during cycle N..N+1 → write, `edit_ptr` or `difficulty` update committed at edge N+1.
- Holding `pushed_store` high produces exactly one event. A new event requires a low sample between presses.
- First `note_valid` asserts P cycles after the first RUN edge; later pulses follow every P cycles.
- `note_valid` is registered and high for exactly one cycle.
- `note_count` and `note_out` update on the same edge as `note_valid` rises.
- `rst` mid-operation returns every register to its reset value on the next edge, regardless of `mode`.
- A mode change lands on the edge the new `mode` is sampled. If RUN→PAUSE coincides with the terminal step count, PAUSE wins and no step is taken.

## Configuration
- `NOTE_SEQ_DEFAULT_SONG_EN` defined: reset loads `mem[i] = 4'b0001 << (i % 4)`, so lanes 0,1,2,3 repeat. This gives a playable song without editing.
- Undefined: reset clears every entry to 4'b0000.
- In both cases EDIT writes overwrite entries, and the memory is not cleared by IDLE.

## Test plan
- Reset, macro defined, STEP_DIV=8, go IDLE→RUN → `note_valid` at cycles 8, 16, 24…; `note_out` 1,2,4,8,1…; `note_count` stops at 41 after 41 pulses.
- EDIT, `lane_btn`=4'b1010, `pushed_store` held high 5 cycles → only `mem[0]`=1010 is written and `edit_ptr`=1. After 41 more presses, `edit_ptr` wraps to 1 again.
- DIFF, four presses → `difficulty` 1,2,0,1. Then RUN with STEP_DIV=8 → pulses every 4 cycles.
- RUN, switch to PAUSE at step count 5 for 20 cycles, then back to RUN → next pulse 3 cycles after resume with `note_count` unchanged during pause.
- RUN with `note_count`=10, then FINISH → `note_out`=0, `note_count`=10, no pulses. Then IDLE → `note_count`=0, `edit_ptr`=0.
- `rst` asserted in RUN with `note_count`=7, macro undefined → all outputs 0 next cycle and `mem` all zero, so later RUN emits `note_out`=0 pulses.
